// File: rtl/jtpang_bank_sched.sv
// Four-slot round-robin scheduler sharing one SDRAM bank; each slot owns a one-entry read cache.
// Optional REQ ack timeout is enabled by defining JTPANG_BANK_TIMEOUT_EN.
module jtpang_bank_sched #(
    parameter int          AW      = 18,
    parameter int          DW      = 32,
    parameter logic [21:0] OFFSET0 = 22'h0,
    parameter logic [21:0] OFFSET1 = 22'h0,
    parameter logic [21:0] OFFSET2 = 22'h0,
    parameter logic [21:0] OFFSET3 = 22'h0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            downloading,
    input  logic [3:0]      slot_cs,
    input  logic [4*AW-1:0] slot_addr,
    output logic [3:0]      slot_ok,
    output logic [4*DW-1:0] slot_dout,
    output logic [21:0]     sdram_addr,
    output logic            sdram_req,
    input  logic            sdram_ack,
    input  logic            data_dst,
    input  logic            data_rdy,
    input  logic [15:0]     data_read,
    output logic            timeout
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t          r_state, w_state_next;
    logic [1:0]      r_ptr, r_gnt, w_win;
    logic            w_any_miss;
    logic [AW-1:0]   r_tag_pend, w_slot_addr;
    logic [3:0]      r_valid, w_hit, w_miss;
    logic [AW-1:0]   r_tag  [4];
    logic [DW-1:0]   r_dout [4];
    logic [15:0]     r_buf, w_lo;
    logic [21:0]     r_addr, w_req_addr, w_off, w_scaled;
    logic            r_req, r_abort;
    logic            w_fill, w_ack_to;
    logic [DW-1:0]   w_fill_data;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_slot
            assign w_hit[gi]  = slot_cs[gi] & r_valid[gi] & ~downloading &
                                (slot_addr[gi*AW +: AW] == r_tag[gi]);
            assign w_miss[gi] = slot_cs[gi] & ~w_hit[gi] & ~downloading;
            assign slot_dout[gi*DW +: DW] = r_dout[gi];
        end
    endgenerate

    assign slot_ok    = w_hit;
    assign sdram_req  = r_req;
    assign sdram_addr = r_addr;

    // Scan from ptr upward; the descending loop lets the closest slot overwrite later ones.
    always_comb begin
        w_win      = r_ptr;
        w_any_miss = 1'b0;
        for (int k = 3; k >= 0; k--) begin
            if (w_miss[r_ptr + 2'(k)]) begin
                w_win      = r_ptr + 2'(k);
                w_any_miss = 1'b1;
            end
        end
    end

    always_comb begin
        w_slot_addr = slot_addr[w_win*AW +: AW];
        case (w_win)
            2'd0:    w_off = OFFSET0;
            2'd1:    w_off = OFFSET1;
            2'd2:    w_off = OFFSET2;
            default: w_off = OFFSET3;
        endcase
        if (DW == 32) w_scaled = 22'({w_slot_addr, 1'b0});
        else          w_scaled = 22'(w_slot_addr);
        w_req_addr = w_off + w_scaled;
    end

    // A word arriving with dst in the completing cycle takes precedence over the buffer.
    always_comb begin
        w_lo        = data_dst ? data_read : r_buf;
        w_fill_data = (DW == 32) ? DW'({data_read, w_lo}) : DW'(w_lo);
    end

`ifdef JTPANG_BANK_TIMEOUT_EN
    logic [7:0] r_cnt;
    logic       r_timeout;

    assign w_ack_to = (r_state == REQ) & ~sdram_ack & (r_cnt == 8'd254);
    assign timeout  = r_timeout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= 8'd0;
            r_timeout <= 1'b0;
        end else begin
            r_cnt <= (r_state == REQ) ? r_cnt + 8'd1 : 8'd0;
            if (w_ack_to) r_timeout <= 1'b1;
        end
    end
`else
    assign w_ack_to = 1'b0;
    assign timeout  = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_fill       = 1'b0;
        case (r_state)
            IDLE: if (w_any_miss) w_state_next = REQ;
            REQ: begin
                if (sdram_ack)     w_state_next = WAIT;
                else if (w_ack_to) w_state_next = IDLE;
            end
            WAIT: begin
                if (data_rdy) begin
                    w_fill       = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr      <= 2'd0;
            r_gnt      <= 2'd0;
            r_tag_pend <= '0;
            r_buf      <= 16'd0;
            r_addr     <= 22'd0;
            r_req      <= 1'b0;
            r_abort    <= 1'b0;
        end else begin
            r_req <= (w_state_next == REQ);
            if (r_state == IDLE && w_any_miss) begin
                r_gnt      <= w_win;
                r_ptr      <= w_win + 2'd1;
                r_tag_pend <= w_slot_addr;
                r_addr     <= w_req_addr;
                r_abort    <= 1'b0;
            end else if (downloading) begin
                r_abort <= 1'b1;
            end
            if (r_state == WAIT && data_dst) r_buf <= data_read;
        end
    end

    // A fill that saw downloading at any point updates data and tag but stays invalid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 4'd0;
            for (int i = 0; i < 4; i++) begin
                r_tag[i]  <= '0;
                r_dout[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (w_fill && r_gnt == 2'(i)) begin
                    r_tag[i]   <= r_tag_pend;
                    r_dout[i]  <= w_fill_data;
                    r_valid[i] <= ~downloading & ~r_abort;
                end else if (downloading) begin
                    r_valid[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_jtpang_bank_sched.sv
// Bench for jtpang_bank_sched: scoreboarded SDRAM responder, hit-vector table, corner sequences.
module tb_jtpang_bank_sched;
    localparam int AW = 18;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst_n, downloading, sdram_ack, data_dst, data_rdy;
    logic            sdram_req, timeout;
    logic [3:0]      slot_cs, slot_ok;
    logic [4*AW-1:0] slot_addr;
    logic [4*DW-1:0] slot_dout;
    logic [21:0]     sdram_addr;
    logic [15:0]     data_read;

    int n_err = 0;
    int n_chk = 0;

    typedef struct {
        logic [1:0]  slot;
        logic [21:0] addr;
        logic [15:0] lo;
        logic [15:0] hi;
    } exp_t;
    exp_t sb_q[$];

    typedef struct {
        logic [3:0]      cs;
        logic [4*AW-1:0] addr;
        logic            dl;
        logic [3:0]      ok;
    } vec_t;
    vec_t vecs[7];

    always #5 clk = ~clk;

    jtpang_bank_sched #(
        .AW(AW), .DW(DW),
        .OFFSET0(22'h0), .OFFSET1(22'h0), .OFFSET2(22'h3F_FFF0), .OFFSET3(22'h100)
    ) dut (
        .clk(clk), .rst_n(rst_n), .downloading(downloading),
        .slot_cs(slot_cs), .slot_addr(slot_addr), .slot_ok(slot_ok), .slot_dout(slot_dout),
        .sdram_addr(sdram_addr), .sdram_req(sdram_req), .sdram_ack(sdram_ack),
        .data_dst(data_dst), .data_rdy(data_rdy), .data_read(data_read), .timeout(timeout)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s = %0h", name, act);
        end
    endtask

    task automatic set_addr(input int n, input logic [17:0] a);
        slot_addr[n*AW +: AW] = a;
    endtask

    task automatic push(input logic [1:0] s, input logic [21:0] a);
        exp_t e;
        e.slot = s;
        e.addr = a;
        e.lo   = a[15:0] ^ 16'hA5A5;
        e.hi   = {a[7:0], 2'b00, a[21:16]} + 16'h1111;
        sb_q.push_back(e);
    endtask

    // Wait for a request, check it against the scoreboard head and answer it.
    task automatic serve(input int ack_dly, input bit dl_wait, input int chg_slot,
                         input logic [17:0] chg_addr);
        exp_t e;
        int   w;
        w = 0;
        while (!sdram_req && w < 64) begin
            tick;
            w++;
        end
        if (!sdram_req) begin
            chk("req_seen", 64'(sdram_req), 64'd1);
            return;
        end
        if (sb_q.size() == 0) begin
            chk("scoreboard_nonempty", 64'(sb_q.size()), 64'd1);
            return;
        end
        e = sb_q.pop_front();
        chk($sformatf("slot%0d sdram_addr", e.slot), 64'(sdram_addr), 64'(e.addr));
        for (int i = 0; i < ack_dly; i++) begin
            tick;
            chk("req_held", 64'(sdram_req), 64'd1);
        end
        sdram_ack = 1'b1;
        tick;
        sdram_ack = 1'b0;
        chk("req_drop_after_ack", 64'(sdram_req), 64'd0);
        if (dl_wait) downloading = 1'b1;
        if (chg_slot >= 0) set_addr(chg_slot, chg_addr);
        data_dst  = 1'b1;
        data_read = e.lo;
        tick;
        data_dst  = 1'b0;
        data_rdy  = 1'b1;
        data_read = e.hi;
        tick;
        data_rdy  = 1'b0;
        data_read = 16'h0;
        chk($sformatf("slot%0d dout", e.slot), 64'(slot_dout[e.slot*DW +: DW]), 64'({e.hi, e.lo}));
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        tick;
        tick;
        rst_n = 1'b1;
        tick;
    endtask

    initial begin
        logic [4*AW-1:0] base;
        exp_t            e1;
        int              cnt;

        rst_n = 1'b0; downloading = 1'b0; sdram_ack = 1'b0; data_dst = 1'b0;
        data_rdy = 1'b0; data_read = 16'h0; slot_cs = 4'h0; slot_addr = '0;
        tick;
        tick;
        chk("reset slot_ok", 64'(slot_ok), 64'd0);
        chk("reset slot_dout", 64'(slot_dout[63:0]) | 64'(slot_dout[127:64]), 64'd0);
        chk("reset sdram_req", 64'(sdram_req), 64'd0);
        chk("reset sdram_addr", 64'(sdram_addr), 64'd0);
        chk("reset timeout", 64'(timeout), 64'd0);
        rst_n = 1'b1;
        tick;

        // Basic miss then hit on slot 0.
        slot_cs = 4'b0001;
        set_addr(0, 18'h00010);
        #1;
        chk("t1 ok in miss cycle", 64'(slot_ok[0]), 64'd0);
        chk("t1 no req in miss cycle", 64'(sdram_req), 64'd0);
        tick;
        chk("t1 req after one cycle", 64'(sdram_req), 64'd1);
        e1.slot = 2'd0; e1.addr = 22'h20; e1.lo = 16'h1234; e1.hi = 16'h5678;
        sb_q.push_back(e1);
        serve(3, 1'b0, -1, 18'h0);
        chk("t1 ok after rdy", 64'(slot_ok[0]), 64'd1);
        chk("t1 dout", 64'(slot_dout[31:0]), 64'h5678_1234);
        tick;
        chk("t1 repeat hit ok", 64'(slot_ok[0]), 64'd1);
        chk("t1 repeat no req", 64'(sdram_req), 64'd0);
        slot_cs = 4'h0;
        tick;

        // Four simultaneous misses from ptr=0, includes the OFFSET2 wrap on slot 2.
        do_reset;
        set_addr(0, 18'h00100);
        set_addr(1, 18'h02000);
        set_addr(2, 18'h00010);
        set_addr(3, 18'h3FFFF);
        slot_cs = 4'hF;
        push(2'd0, 22'h000200);
        push(2'd1, 22'h004000);
        push(2'd2, 22'h000010);
        push(2'd3, 22'h0800FE);
        for (int i = 0; i < 4; i++) serve(1, 1'b0, -1, 18'h0);
        chk("t2 all ok", 64'(slot_ok), 64'hF);
        slot_cs = 4'b1010;
        set_addr(1, 18'h00ABC);
        set_addr(3, 18'h00001);
        push(2'd1, 22'h001578);
        push(2'd3, 22'h000102);
        for (int i = 0; i < 2; i++) serve(0, 1'b0, -1, 18'h0);
        chk("t2b ok", 64'(slot_ok), 64'hA);
        slot_cs = 4'h0;
        tick;

        // Combinational hit table against the caches filled above.
        base = {18'h00001, 18'h00010, 18'h00ABC, 18'h00100};
        vecs[0] = '{4'hF, base, 1'b0, 4'hF};
        vecs[1] = '{4'hF, base, 1'b1, 4'h0};
        vecs[2] = '{4'h5, base, 1'b0, 4'h5};
        vecs[3] = '{4'hF, base ^ (72'd1 << (2*AW)), 1'b0, 4'hB};
        vecs[4] = '{4'h0, base, 1'b0, 4'h0};
        vecs[5] = '{4'hA, base ^ (72'd4 << AW), 1'b0, 4'h8};
        vecs[6] = '{4'hC, base ^ (72'd2 << (3*AW)), 1'b0, 4'h4};
        for (int i = 0; i < 7; i++) begin
            slot_cs     = vecs[i].cs;
            slot_addr   = vecs[i].addr;
            downloading = vecs[i].dl;
            #1;
            chk($sformatf("vec%0d slot_ok", i), 64'(slot_ok), 64'(vecs[i].ok));
            #1;
            slot_cs     = 4'h0;
            downloading = 1'b0;
            tick;
        end
        slot_addr = base;

        // Download rises during WAIT: fill completes but stays invalid.
        slot_cs = 4'b0001;
        set_addr(0, 18'h00222);
        push(2'd0, 22'h000444);
        serve(2, 1'b1, -1, 18'h0);
        for (int i = 0; i < 3; i++) begin
            chk("t4 no req while downloading", 64'(sdram_req), 64'd0);
            tick;
        end
        downloading = 1'b0;
        slot_cs = 4'b1001;
        #1;
        chk("t4 caches invalid after download", 64'(slot_ok), 64'd0);
        push(2'd3, 22'h000102);
        push(2'd0, 22'h000444);
        serve(1, 1'b0, -1, 18'h0);
        serve(1, 1'b0, -1, 18'h0);
        chk("t4 refilled ok", 64'(slot_ok), 64'h9);
        slot_cs = 4'h0;
        tick;

        // Address change during WAIT: tag takes the old address, new address re-requests.
        slot_cs = 4'b0010;
        set_addr(1, 18'h00005);
        push(2'd1, 22'h00000A);
        serve(0, 1'b0, 1, 18'h00006);
        chk("t5 ok with new addr", 64'(slot_ok[1]), 64'd0);
        #1;
        set_addr(1, 18'h00005);
        #1;
        chk("t5 tag holds old addr", 64'(slot_ok[1]), 64'd1);
        set_addr(1, 18'h00006);
        push(2'd1, 22'h00000C);
        serve(2, 1'b0, -1, 18'h0);
        chk("t5 ok after second fill", 64'(slot_ok[1]), 64'd1);
        slot_cs = 4'h0;
        tick;

        // Ack never arrives.
        slot_cs = 4'b0100;
        set_addr(2, 18'h00020);
        cnt = 0;
        while (!sdram_req && cnt < 64) begin
            tick;
            cnt++;
        end
        chk("t6 req seen", 64'(sdram_req), 64'd1);
        chk("t6 sdram_addr wrap", 64'(sdram_addr), 64'h30);
`ifdef JTPANG_BANK_TIMEOUT_EN
        cnt = 0;
        while (sdram_req && cnt < 400) begin
            cnt++;
            tick;
        end
        chk("t6 req high cycles", 64'(cnt), 64'd255);
        chk("t6 timeout set", 64'(timeout), 64'd1);
        tick;
        chk("t6 re-request", 64'(sdram_req), 64'd1);
`else
        for (int i = 0; i < 300; i++) tick;
        chk("t6 req still waiting", 64'(sdram_req), 64'd1);
        chk("t6 timeout tied low", 64'(timeout), 64'd0);
`endif
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6 async reset req", 64'(sdram_req), 64'd0);
        chk("t6 async reset addr", 64'(sdram_addr), 64'd0);
        chk("t6 async reset timeout", 64'(timeout), 64'd0);
        chk("t6 async reset ok", 64'(slot_ok), 64'd0);
        chk("t6 async reset dout", 64'(slot_dout[63:0]) | 64'(slot_dout[127:64]), 64'd0);
        slot_cs = 4'h0;
        tick;
        rst_n = 1'b1;
        tick;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
